fft_1024_frame_sequencer: RTL
=============================

// Module: fft_1024_frame_sequencer
// PURPOSE
// - Sequences the 8-stage 1024-point streaming FFT pipeline: accepts complex samples on a valid/ready input stream, drives the core's frame-start, enable and data inputs, and re-frames core output into a valid/ready output stream.
// - Stalls the whole core with its enable on input gaps or output backpressure, and drains in-flight frames by clocking zeros between frames.
// - Sits between the sample source and the core; all core flow control belongs here.
// PARAMETERS
// - N        1024  points per frame; power of two
// - LOG2N    10    log2(N); counter width
// - DW       16    per-component sample width (re/im, two's complement)
// - FIFO_D   4     output FIFO depth, >=3
// PORTS
// clock_c      in   1      single clock, rising edge
// reset_n      in   1      asynchronous active-low reset
// in_valid     in   1      input sample valid
// in_ready     out  1      input sample accepted when in_valid&in_ready
// in_re/in_im  in   DW     input sample real/imag
// abort        in   1      sync pulse: discard all frames in progress
// core_start   out  1      to core frame-start: high with sample 0 of each frame
// core_xr/xi   out  DW     to core data inputs
// core_en      out  1      to core enable: core advances one step on edges where high
// core_clr     out  1      to core sync clear
// core_ovalid  in   1      from core: marks output sample 0 of a frame
// core_yr/yi   in   DW     from core output data
// out_valid    out  1      output FIFO not empty
// out_ready    in   1      downstream accepts
// out_re/out_im out DW     output sample (FIFO head)
// out_last     out  1      with output sample N-1
// busy         out  1      frames_pend!=0 or in_cnt!=0
// err_sync     out  1      sticky: core_ovalid while output frame active
// BEHAVIOUR
// - Reset: all outputs 0 except core_clr=1 for the first cycle after reset_n rises; counters 0, FIFO empty, err_sync=0.
// - room = (fifo_cnt + en_d) <= FIFO_D-2, where en_d = core_en registered one cycle.
// - in_ready = room & ~core_clr & ~abort; accept = in_valid & in_ready.
// - drain = ~in_valid & in_cnt==0 & frames_pend!=0 & room.
// - core_en = accept | drain. Mid-frame input gap (in_cnt!=0, ~in_valid): core_en=0, core fully stalled.
// - core_xr/xi = accepted sample, else 0. core_start = accept & in_cnt==0. All core_* outputs are combinational.
// - in_cnt (LOG2N bits) increments per accept and wraps N-1 -> 0; on wrap frames_pend++.
// - Capture: core output is sampled in cycles with en_d=1. If core_ovalid, or out_cnt!=0: push {core_yr,core_yi,last=(out_cnt==N-1)} into FIFO; out_cnt wraps N-1 -> 0.
// - Last output sample pushed: frames_pend--. Same-cycle ++ and -- leaves frames_pend unchanged.
// - core_ovalid while out_cnt!=0: set err_sync; treat as sample 0 (out_cnt restarts at 1).
// - FIFO: push and pop allowed in the same cycle. Full is unreachable by construction of room; an assertion checks it.
// - Output pop = out_valid & out_ready. out_valid, out_re, out_im and out_last come from FIFO head.
// - abort: next cycle in_cnt, out_cnt and frames_pend = 0; FIFO flushed; core_clr=1 for 1 cycle. err_sync kept; cleared only by reset.
// - reset_n low mid-frame: immediate async clear as above. Partial frames are lost.
// - frames_pend width LOG2N+1. Saturation is impossible: throughput is bounded by core latency.
// STRUCTURE
// - Shared pkg fft_pkg: N, LOG2N, DW, complex sample typedef {re,im}.
// - One sub-module: fft_seq_ofifo (synchronous FIFO, width 2*DW+1, depth FIFO_D, with count output).
// - Top level holds the in/out counters, frames_pend and the enable/drain logic.
// TESTING
// - Ramp 2 frames back-to-back, out_ready=1: core_start pulses on input samples 0 and 1024. The model's frame 0 follows by drain with no gaps; out_last fires exactly at output samples 1023 and 2047; busy then drops to 0.
// - Impulse x[0]=(16'h4000,0), rest 0: all 1024 outputs equal the golden core model; frames_pend goes 1 -> 0.
// - Input gap of 37 cycles at sample 500: core_en=0 for those 37 cycles. The output frame is bit-identical to the no-gap run.
// - out_ready toggled 1/0 pseudo-randomly (50%): no FIFO overflow assertion, no dropped or duplicated samples, and output count = 1024 per frame.
// - abort at in sample 700 with 1 frame pending: next cycle core_clr=1 and FIFO empty. A fresh frame after that is correct, and err_sync stays 0.
// - Inject core_ovalid at output sample 10: err_sync=1, out_cnt restarts; reset_n low then clears err_sync to 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and sample types for the 1024-point streaming FFT datapath.
package fft_pkg;
    localparam int N     = 1024;
    localparam int LOG2N = 10;
    localparam int DW    = 16;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Output FIFO entry: one core output sample plus its end-of-frame flag.
    typedef struct packed {
        logic  last;
        cplx_t smp;
    } ofifo_word_t;
endpackage

// File: rtl/fft_seq_ofifo.sv
// Synchronous FIFO holding re-framed core output; head is shown combinationally.
module fft_seq_ofifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // The upstream room check keeps the FIFO below full at every push.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/fft_1024_frame_sequencer.sv
// Flow-control wrapper for the 8-stage 1024-point streaming FFT core: framing,
// stall/drain enable generation and re-framing of core output into a stream.
module fft_1024_frame_sequencer
    import fft_pkg::*;
#(
    parameter int FIFO_D = 4
) (
    input  logic          clock_c,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          abort,
    output logic          core_start,
    output logic [DW-1:0] core_xr,
    output logic [DW-1:0] core_xi,
    output logic          core_en,
    output logic          core_clr,
    input  logic          core_ovalid,
    input  logic [DW-1:0] core_yr,
    input  logic [DW-1:0] core_yi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy,
    output logic          err_sync
);
    localparam int CW = $clog2(FIFO_D+1);

    logic [LOG2N-1:0] in_cnt;
    logic [LOG2N-1:0] out_cnt;
    logic [LOG2N:0]   frames_pend;
    logic             en_d;
    logic             clr_q;
    logic             err_q;

    logic             room;
    logic             accept;
    logic             drain;
    logic             in_wrap;
    logic             cap;
    logic             cap_last;
    logic             sync_err;
    logic [LOG2N-1:0] cap_idx;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    ofifo_word_t      push_w;
    ofifo_word_t      head_w;

    // Both streams use strict valid/ready: a transfer happens on a rising edge
    // where valid and ready are both high; valid never waits on ready.
    // Room also counts the capture already in flight from last cycle's enable.
    assign room     = (int'(fifo_cnt) + int'(en_d)) <= (FIFO_D - 2);
    assign in_ready = room & ~clr_q & ~abort;
    assign accept   = in_valid & in_ready;
    assign drain    = ~in_valid & (in_cnt == '0) & (frames_pend != '0) & room;
    assign in_wrap  = accept & (in_cnt == LOG2N'(N-1));

    assign core_en    = accept | drain;
    assign core_start = accept & (in_cnt == '0);
    assign core_xr    = accept ? in_re : '0;
    assign core_xi    = accept ? in_im : '0;
    assign core_clr   = clr_q;

    // A core frame marker always restarts output framing, even mid-frame.
    assign cap_idx  = core_ovalid ? '0 : out_cnt;
    assign cap      = en_d & (core_ovalid | (out_cnt != '0));
    assign cap_last = cap & (cap_idx == LOG2N'(N-1));
    assign sync_err = en_d & core_ovalid & (out_cnt != '0);

    assign push_w.last   = cap_last;
    assign push_w.smp.re = core_yr;
    assign push_w.smp.im = core_yi;

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt      <= '0;
            out_cnt     <= '0;
            frames_pend <= '0;
            en_d        <= 1'b0;
            clr_q       <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            clr_q <= abort;
            if (sync_err) err_q <= 1'b1;
            if (abort) begin
                in_cnt      <= '0;
                out_cnt     <= '0;
                frames_pend <= '0;
                en_d        <= 1'b0;
            end else begin
                en_d <= core_en;
                if (accept) in_cnt <= in_cnt + LOG2N'(1);
                if (cap) out_cnt <= cap_last ? '0 : cap_idx + LOG2N'(1);
                case ({in_wrap, cap_last})
                    2'b10:   frames_pend <= frames_pend + (LOG2N+1)'(1);
                    2'b01:   if (frames_pend != '0) frames_pend <= frames_pend - (LOG2N+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    assign pop = out_valid & out_ready;

    fft_seq_ofifo #(
        .W     ($bits(ofifo_word_t)),
        .DEPTH (FIFO_D)
    ) u_ofifo (
        .clk   (clock_c),
        .rst_n (reset_n),
        .flush (abort),
        .push  (cap & ~abort),
        .wdata (push_w),
        .pop   (pop),
        .rdata (head_w),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

    assign out_valid = ~fifo_empty;
    assign out_re    = head_w.smp.re;
    assign out_im    = head_w.smp.im;
    assign out_last  = head_w.last;
    assign busy      = (frames_pend != '0) | (in_cnt != '0);
    assign err_sync  = err_q;
endmodule
